// File: rtl/qspi_font_reader.sv
// qspi_font_reader: streams glyph bitmaps from QSPI NOR flash (quad I/O read 0xEB) as 2-bit pixels, one per clk.
// Ports: clk/rst (sync, active high); fetch_start/fetch_addr/fetch_stop request control; busy status;
// pixel_data/pixel_data_valid pixel stream; spi_cs_n/spi_sck/spi_io_out/spi_io_oe/spi_io_in flash pins.
module qspi_font_reader #(
    parameter int         DUMMY_CYCLES   = 4,
    parameter logic [7:0] MODE_BYTE      = 8'hFF,
    parameter int         CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_start,
    input  logic [23:0] fetch_addr,
    input  logic        fetch_stop,
    output logic        busy,
    output logic [1:0]  pixel_data,
    output logic        pixel_data_valid,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic [3:0]  spi_io_out,
    output logic [3:0]  spi_io_oe,
    input  logic [3:0]  spi_io_in
);
    localparam int CW = $clog2((CS_HIGH_CYCLES > 16 ? CS_HIGH_CYCLES : 16) + 1);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, MODE, DUMMY, DATA, END} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [39:0]   sr_q, sr_d;
    logic [1:0]    lo_q, lo_d;
    logic [1:0]    pixel_q, pixel_d;
    logic          valid_q, valid_d;
    logic          cs_n_q, cs_n_d;
    logic          sck_q, sck_d;
    logic [3:0]    io_out_q, io_out_d;
    logic [3:0]    io_oe_q, io_oe_d;
    logic          busy_q, busy_d;
    logic          fall, on_d, cap;
    // cnt_q holds SCK periods left in the current phase minus one (or END clocks left minus one).
    // sr_q holds {command, address, mode}; its top bits are always the value currently on the pins.
    always_comb begin
        fall = state_q != IDLE && state_q != END && sck_q;
        state_d = state_q;
        cnt_d = cnt_q;
        sr_d = sr_q;
        if (state_q == IDLE) begin
            if (fetch_start && !fetch_stop) begin
                state_d = CMD;
                cnt_d = CW'(7);
                sr_d = {8'hEB, fetch_addr, MODE_BYTE};
            end
        end else if (state_q == END) begin
            if (cnt_q == '0) state_d = IDLE;
            else cnt_d = cnt_q - CW'(1);
        end else if (fetch_stop) begin
            state_d = END;
            cnt_d = CW'(CS_HIGH_CYCLES - 1);
        end else if (fall && state_q != DATA) begin
            sr_d = state_q == CMD ? sr_q << 1 : sr_q << 4;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                state_d = state_q == CMD ? ADDR : state_q == ADDR ? MODE : state_q == MODE ? DUMMY : DATA;
                cnt_d = state_q == CMD ? CW'(5) : state_q == ADDR ? CW'(1) : CW'(DUMMY_CYCLES - 1);
            end
        end
        on_d = state_d != IDLE && state_d != END;
        cs_n_d = !on_d;
        // SCK starts low on the accepting edge and toggles every clk afterwards.
        sck_d = on_d && state_q != IDLE && !sck_q;
        io_out_d = state_d == CMD ? {3'b000, sr_d[39]} : (state_d == ADDR || state_d == MODE) ? sr_d[39:36] : 4'h0;
        io_oe_d = state_d == CMD ? 4'b0001 : (state_d == ADDR || state_d == MODE) ? 4'b1111 : 4'b0000;
        // A nibble is captured on each SCK falling edge in DATA except the one that enters DATA.
        cap = state_q == DATA && sck_q && state_d == DATA;
        pixel_d = state_d != DATA ? 2'b00 : cap ? spi_io_in[3:2] : lo_q;
        lo_d = state_d != DATA ? 2'b00 : cap ? spi_io_in[1:0] : lo_q;
        valid_d = state_d == DATA && (cap || valid_q);
        busy_d = state_d != IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sr_q     <= '0;
            lo_q     <= '0;
            pixel_q  <= '0;
            valid_q  <= 1'b0;
            cs_n_q   <= 1'b1;
            sck_q    <= 1'b0;
            io_out_q <= '0;
            io_oe_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sr_q     <= sr_d;
            lo_q     <= lo_d;
            pixel_q  <= pixel_d;
            valid_q  <= valid_d;
            cs_n_q   <= cs_n_d;
            sck_q    <= sck_d;
            io_out_q <= io_out_d;
            io_oe_q  <= io_oe_d;
            busy_q   <= busy_d;
        end
    end
    assign busy             = busy_q;
    assign pixel_data       = pixel_q;
    assign pixel_data_valid = valid_q;
    assign spi_cs_n         = cs_n_q;
    assign spi_sck          = sck_q;
    assign spi_io_out       = io_out_q;
    assign spi_io_oe        = io_oe_q;
endmodule

// File: tb/tb_qspi_font_reader.sv
// tb_qspi_font_reader: randomized bench with a behavioural flash and pixel-stream reference model.
module tb_qspi_font_reader;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst, fetch_start, fetch_stop, busy, pixel_data_valid, spi_cs_n, spi_sck;
    logic [23:0] fetch_addr;
    logic [1:0] pixel_data;
    logic [3:0] spi_io_out, spi_io_oe, spi_io_in;
    logic st6, sp6, busy6, pv6, cs6, sck6;
    logic [23:0] ad6;
    logic [1:0] pd6;
    logic [3:0] io6_out, io6_oe, io_in6;
    always #5 clk = ~clk;
    qspi_font_reader dut (
        .clk(clk), .rst(rst), .fetch_start(fetch_start), .fetch_addr(fetch_addr), .fetch_stop(fetch_stop),
        .busy(busy), .pixel_data(pixel_data), .pixel_data_valid(pixel_data_valid), .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck), .spi_io_out(spi_io_out), .spi_io_oe(spi_io_oe), .spi_io_in(spi_io_in)
    );
    qspi_font_reader #(.DUMMY_CYCLES(6)) dut6 (
        .clk(clk), .rst(rst), .fetch_start(st6), .fetch_addr(ad6), .fetch_stop(sp6),
        .busy(busy6), .pixel_data(pd6), .pixel_data_valid(pv6), .spi_cs_n(cs6),
        .spi_sck(sck6), .spi_io_out(io6_out), .spi_io_oe(io6_oe), .spi_io_in(io_in6)
    );
    int total = 0, bad = 0, n = 0;
    int rises = 0, pix_n = 0, tot_valid = 0;
    logic seen = 1'b0, sck_prev = 1'b0;
    logic [7:0] m_cmd = 8'h00, m_mode = 8'h00;
    logic [23:0] m_addr = '0, cur_addr = '0;
    logic [7:0] mem [256];
    logic [1:0] order [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(negedge clk);
        n++;
    endtask
    function automatic logic [3:0] nib(input int k);
        logic [7:0] b;
        b = mem[8'(m_addr + 24'(k / 2))];
        return (k % 2 == 0) ? b[7:4] : b[3:0];
    endfunction
    function automatic logic [1:0] exp_pix(input int j);
        logic [3:0] v;
        v = nib(j / 2);
        return (j % 2 == 0) ? v[3:2] : v[1:0];
    endfunction
    // Flash model: decodes command/address/mode from SCK rising edges, then supplies one
    // nibble per SCK period from mem; also checks the pixel stream against mem.
    always @(negedge clk) begin
        if (spi_cs_n) begin
            rises = 0;
            seen = 1'b0;
            pix_n = 0;
        end else if (spi_sck && !sck_prev) begin
            rises++;
            if (rises <= 16) chk("oe_phase", spi_io_oe, rises <= 8 ? 4'b0001 : 4'b1111);
            if (rises <= 8) m_cmd = {m_cmd[6:0], spi_io_out[0]};
            else if (rises <= 14) m_addr = {m_addr[19:0], spi_io_out};
            else if (rises <= 16) m_mode = {m_mode[3:0], spi_io_out};
            if (rises == 16) begin
                chk("cmd", m_cmd, 8'hEB);
                chk("addr", m_addr, cur_addr);
                chk("mode", m_mode, 8'hFF);
            end
            if (rises == 17) chk("oe_dummy", spi_io_oe, 4'b0000);
        end
        sck_prev = spi_sck;
        if (!spi_cs_n && pixel_data_valid) begin
            chk("pix", pixel_data, exp_pix(pix_n));
            pix_n++;
            tot_valid++;
            seen = 1'b1;
        end else if (!spi_cs_n && seen) chk("gap", pixel_data_valid, 1);
        spi_io_in = (!spi_cs_n && rises >= 17 + D) ? nib(rises - 17 - D) : 4'($urandom);
    end
    task automatic start(input logic [23:0] a);
        cur_addr = a;
        fetch_addr = a;
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        n = 1;
        chk("e0_cs", spi_cs_n, 0);
        chk("e0_sck", spi_sck, 0);
        chk("e0_io0", spi_io_out[0], 1);
        chk("e0_busy", busy, 1);
    endtask
    task automatic stop_check;
        fetch_stop = 1'b1;
        tick;
        fetch_stop = 1'b0;
        chk("stop_cs", spi_cs_n, 1);
        chk("stop_valid", pixel_data_valid, 0);
        chk("stop_sck", spi_sck, 0);
        chk("stop_oe", spi_io_oe, 0);
        chk("stop_busy", busy, 1);
        tick;
        chk("end_busy", busy, 1);
        tick;
        chk("idle_busy", busy, 0);
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_cs"}, spi_cs_n, 1);
        chk({tag, "_sck"}, spi_sck, 0);
        chk({tag, "_io"}, spi_io_out, 0);
        chk({tag, "_oe"}, spi_io_oe, 0);
        chk({tag, "_pix"}, pixel_data, 0);
        chk({tag, "_valid"}, pixel_data_valid, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int len, v0, hi;
        logic [3:0] nb;
        rst = 1'b1;
        fetch_start = 1'b0;
        fetch_stop = 1'b0;
        fetch_addr = '0;
        st6 = 1'b0;
        sp6 = 1'b0;
        ad6 = '0;
        io_in6 = '0;
        foreach (mem[i]) mem[i] = 8'($urandom);
        repeat (3) tick;
        chk_reset("rst");
        chk("rst6_cs", cs6, 1);
        rst = 1'b0;
        tick;
        // Full read at 0x012345 with known bytes for pixel order.
        mem[8'h45] = 8'hE4;
        mem[8'h46] = 8'h1B;
        start(24'h012345);
        while (n < 32) tick;
        chk("mode_oe", spi_io_oe, 4'hF);
        chk("mode_io", spi_io_out, 4'hF);
        tick;
        chk("e32_oe", spi_io_oe, 0);
        while (!pixel_data_valid && n < 100) tick;
        chk("first_valid", n, 43);
        for (int i = 0; i < 8; i++) begin
            chk("order_valid", pixel_data_valid, 1);
            chk("order_pix", pixel_data, order[i]);
            tick;
        end
        // Start pulse during DATA must be ignored.
        fetch_addr = 24'($urandom);
        fetch_start = 1'b1;
        tick;
        fetch_start = 1'b0;
        chk("ign_busy", busy, 1);
        chk("ign_cs", spi_cs_n, 0);
        chk("ign_valid", pixel_data_valid, 1);
        repeat (20) tick;
        stop_check();
        // Random addresses, contents and stop points.
        for (int r = 0; r < 6; r++) begin
            foreach (mem[i]) mem[i] = 8'($urandom);
            len = $urandom_range(25, 110);
            v0 = tot_valid;
            start(24'($urandom));
            repeat (len) tick;
            fetch_stop = 1'b1;
            tick;
            fetch_stop = 1'b0;
            chk("npix", tot_valid - v0, len >= 42 ? len - 41 : 0);
            chk("rnd_cs", spi_cs_n, 1);
            repeat (2) tick;
            chk("rnd_idle", busy, 0);
        end
        // Stop during ADDR at E20.
        v0 = tot_valid;
        start(24'($urandom));
        repeat (19) tick;
        fetch_stop = 1'b1;
        tick;
        fetch_stop = 1'b0;
        chk("e20_cs", spi_cs_n, 1);
        chk("e20_valid", pixel_data_valid, 0);
        tick;
        chk("e21_busy", busy, 1);
        tick;
        chk("e22_busy", busy, 0);
        repeat (50) tick;
        chk("e20_nopix", tot_valid - v0, 0);
        // Start and stop together in IDLE.
        fetch_start = 1'b1;
        fetch_stop = 1'b1;
        tick;
        fetch_start = 1'b0;
        fetch_stop = 1'b0;
        chk("ss_busy", busy, 0);
        chk("ss_cs", spi_cs_n, 1);
        repeat (5) tick;
        chk("ss_busy2", busy, 0);
        // Reset mid-DATA, then a fresh fetch must run from IDLE.
        start(24'($urandom));
        repeat (60) tick;
        chk("pre_rst_valid", pixel_data_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk_reset("mid_rst");
        start(24'($urandom));
        while (!pixel_data_valid && n < 100) tick;
        chk("rst_first_valid", n, 43);
        repeat (10) tick;
        stop_check();
        // DUMMY_CYCLES=6: pad value equals cycle index, so capture edge shows in the pixels.
        ad6 = 24'($urandom);
        st6 = 1'b1;
        tick;
        st6 = 1'b0;
        n = 1;
        chk("d6_cs", cs6, 0);
        while (!pv6 && n < 100) begin
            io_in6 = 4'(n);
            tick;
        end
        chk("d6_first", n, 47);
        for (int i = 0; i < 8; i++) begin
            io_in6 = 4'(n);
            nb = 4'(n[0] ? n - 1 : n - 2);
            chk("d6_valid", pv6, 1);
            chk("d6_pix", pd6, n[0] ? nb[3:2] : nb[1:0]);
            tick;
        end
        sp6 = 1'b1;
        tick;
        sp6 = 1'b0;
        chk("d6_stop_cs", cs6, 1);
        chk("d6_stop_valid", pv6, 0);
        hi = 0;
        while (cs6 && hi < 50) begin
            st6 = !busy6;
            tick;
            hi++;
        end
        st6 = 1'b0;
        chk("d6_cshigh", hi >= 2, 1);
        chk("d6_restart", cs6, 0);
        sp6 = 1'b1;
        tick;
        sp6 = 1'b0;
        repeat (4) tick;
        chk("d6_idle", busy6, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
